// File: rtl/qspim_if.sv
`default_nettype none
// ============================================================================
// Module   : qspim_if
// Purpose  : Quad-SPI master bridge. Turns one register-style read or write
//            request into a complete quad-lane SPI frame. Frame layout:
//            command byte {op, be}, 24-bit address, then either 32 bits of
//            write data or DUMMY_CYC turnaround clocks followed by 32 bits
//            of read data. All phases use four lanes, most-significant
//            nibble first. SPI mode 0 is used (sclk idles low).
// Ports    : sys_clk    - single system clock, rising edge
//            rst        - asynchronous active-high reset
//            reg_wr/rd  - level requests, held until reg_ack
//            reg_addr   - 24-bit transfer address
//            reg_be     - byte enables, sent in the command byte
//            reg_wdata  - write data
//            reg_rdata  - read data, updated with the read's reg_ack
//            reg_ack    - one-cycle completion pulse
//            reg_busy   - high while a frame is in progress
//            sclk/ssn   - SPI clock and active-low chip select
//            sdout      - quad data to slave, sdout_oen active-low enable
//            sdin       - quad data from slave
// Revision : 1.0 - initial release
// ============================================================================
module qspim_if #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned DUMMY_CYC = 2
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [23:0] reg_addr,
    input  logic [3:0]  reg_be,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        reg_ack,
    output logic        reg_busy,
    output logic        sclk,
    output logic        ssn,
    output logic [3:0]  sdout,
    output logic        sdout_oen,
    input  logic [3:0]  sdin
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        CS_SETUP = 4'd1,
        CMD      = 4'd2,
        ADDR     = 4'd3,
        WDATA    = 4'd4,
        DUMMY    = 4'd5,
        RDATA    = 4'd6,
        CS_HOLD  = 4'd7,
        CS_IDLE  = 4'd8
    } state_t;

    localparam logic [7:0] c_div_last   = 8'(CLK_DIV - 1);
    localparam logic [7:0] c_ack_pre    = (CLK_DIV > 1) ? 8'(CLK_DIV - 2) : 8'd0;
    localparam bit         c_div_one    = (CLK_DIV == 1);
    localparam logic [3:0] c_dummy_last = 4'(DUMMY_CYC - 1);
    localparam logic [3:0] c_op_wr      = 4'h2;
    localparam logic [3:0] c_op_rd      = 4'h3;

    state_t      state_q;
    logic [7:0]  div_q;      // sys_clk count within the current sclk half-period
    logic [3:0]  cyc_q;      // sclk cycle count within the current phase
    logic        is_rd_q;
    logic [59:0] sh_q;       // nibbles still to send after the one on sdout
    logic [31:0] rx_q;
    logic        sclk_q;
    logic        ssn_q;
    logic [3:0]  sdout_q;
    logic        oen_q;
    logic        ack_q;
    logic        busy_q;
    logic [31:0] rdata_q;

    logic        w_div_end;
    logic        w_cyc_end;
    logic        w_ack_set;
    logic [3:0]  w_phase_last;

    assign w_div_end = (div_q == c_div_last);
    assign w_cyc_end = (cyc_q == w_phase_last);

    // reg_ack must be high in the final CS_IDLE cycle, so it is set one
    // cycle earlier; with CLK_DIV=1 that earlier cycle is the last CS_HOLD one.
    assign w_ack_set = c_div_one ? ((state_q == CS_HOLD) && w_div_end)
                                 : ((state_q == CS_IDLE) && (div_q == c_ack_pre));

    always_comb begin
        w_phase_last = 4'd0;
        case (state_q)
            CMD:     w_phase_last = 4'd1;
            ADDR:    w_phase_last = 4'd5;
            WDATA:   w_phase_last = 4'd7;
            DUMMY:   w_phase_last = c_dummy_last;
            RDATA:   w_phase_last = 4'd7;
            default: w_phase_last = 4'd0;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            cyc_q   <= '0;
            is_rd_q <= 1'b0;
            sh_q    <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b0;
            ssn_q   <= 1'b1;
            sdout_q <= '0;
            oen_q   <= 1'b1;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    div_q <= '0;
                    cyc_q <= '0;
                    if (reg_wr || reg_rd) begin
                        state_q <= CS_SETUP;
                        is_rd_q <= ~reg_wr;
                        // First command nibble goes out with chip select.
                        sdout_q <= reg_wr ? c_op_wr : c_op_rd;
                        sh_q    <= {reg_be, reg_addr, reg_wdata};
                        oen_q   <= 1'b0;
                        ssn_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end

                CS_SETUP: begin
                    if (w_div_end) begin
                        div_q   <= '0;
                        state_q <= CMD;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end

                CMD, ADDR, WDATA, DUMMY, RDATA: begin
                    if (!w_div_end) begin
                        div_q <= div_q + 8'd1;
                    end else begin
                        div_q  <= '0;
                        sclk_q <= ~sclk_q;
                        if (!sclk_q) begin
                            // Rising sclk: slave data has been stable since the
                            // previous falling edge.
                            if (state_q == RDATA) begin
                                rx_q <= {rx_q[27:0], sdin};
                            end
                        end else begin
                            // Falling sclk ends one sclk cycle.
                            if (state_q inside {CMD, ADDR, WDATA}) begin
                                sdout_q <= sh_q[59:56];
                                sh_q    <= {sh_q[55:0], 4'h0};
                            end
                            if (w_cyc_end) begin
                                cyc_q <= '0;
                                case (state_q)
                                    CMD: state_q <= ADDR;
                                    ADDR: begin
                                        if (is_rd_q) begin
                                            state_q <= DUMMY;
                                            sdout_q <= '0;
                                            oen_q   <= 1'b1;
                                        end else begin
                                            state_q <= WDATA;
                                        end
                                    end
                                    WDATA: begin
                                        state_q <= CS_HOLD;
                                        sdout_q <= '0;
                                        oen_q   <= 1'b1;
                                    end
                                    DUMMY:   state_q <= RDATA;
                                    default: state_q <= CS_HOLD;
                                endcase
                            end else begin
                                cyc_q <= cyc_q + 4'd1;
                            end
                        end
                    end
                end

                CS_HOLD: begin
                    if (w_div_end) begin
                        div_q   <= '0;
                        ssn_q   <= 1'b1;
                        state_q <= CS_IDLE;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end

                CS_IDLE: begin
                    if (w_div_end) begin
                        div_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end

                default: state_q <= IDLE;
            endcase

            if (w_ack_set) begin
                ack_q <= 1'b1;
                if (is_rd_q) begin
                    rdata_q <= rx_q;
                end
            end
        end
    end

    assign reg_rdata = rdata_q;
    assign reg_ack   = ack_q;
    assign reg_busy  = busy_q;
    assign sclk      = sclk_q;
    assign ssn       = ssn_q;
    assign sdout     = sdout_q;
    assign sdout_oen = oen_q;

endmodule
`default_nettype wire

// File: tb/tb_qspim_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_qspim_if
// Purpose  : Directed self-checking bench for qspim_if. One instance runs
//            with CLK_DIV=2/DUMMY_CYC=2, a second with CLK_DIV=1 for the
//            back-to-back frames.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_qspim_if;

    logic        clk;
    logic        rst;

    logic        reg_wr, reg_rd;
    logic [23:0] reg_addr;
    logic [3:0]  reg_be;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_ack, reg_busy;
    logic        sclk, ssn, sdout_oen;
    logic [3:0]  sdout;
    logic [3:0]  sdin;

    logic        wr1, rd1;
    logic [23:0] addr1;
    logic [3:0]  be1;
    logic [31:0] wdata1;
    logic [31:0] rdata1;
    logic        ack1, busy1;
    logic        sclk1, ssn1, oen1;
    logic [3:0]  sdout1;
    logic [3:0]  sdin1;

    int checks = 0;
    int errors = 0;

    logic [3:0]  mon_nib [32];
    logic        mon_oen [32];
    int          mon_n = 0;
    int          rise_cnt = 0;
    logic [31:0] slave_word = 32'hDEADBEEF;

    qspim_if #(.CLK_DIV(2), .DUMMY_CYC(2)) dut (
        .sys_clk(clk), .rst(rst),
        .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_be(reg_be),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
        .reg_busy(reg_busy), .sclk(sclk), .ssn(ssn), .sdout(sdout),
        .sdout_oen(sdout_oen), .sdin(sdin)
    );

    qspim_if #(.CLK_DIV(1), .DUMMY_CYC(2)) dut1 (
        .sys_clk(clk), .rst(rst),
        .reg_wr(wr1), .reg_rd(rd1), .reg_addr(addr1), .reg_be(be1),
        .reg_wdata(wdata1), .reg_rdata(rdata1), .reg_ack(ack1),
        .reg_busy(busy1), .sclk(sclk1), .ssn(ssn1), .sdout(sdout1),
        .sdout_oen(oen1), .sdin(sdin1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus monitor: nibble and output enable seen at every rising sclk.
    always @(posedge sclk) begin
        if (!ssn) begin
            if (mon_n < 32) begin
                mon_nib[mon_n] = sdout;
                mon_oen[mon_n] = sdout_oen;
            end
            mon_n    = mon_n + 1;
            rise_cnt = rise_cnt + 1;
        end
    end

    // Slave model: after 8 command/address clocks and 2 dummy clocks it
    // shifts slave_word out on falling sclk, MS nibble first.
    always @(negedge ssn) begin
        rise_cnt = 0;
        sdin     = 4'h0;
    end

    always @(negedge sclk) begin
        if (!ssn && rise_cnt >= 10 && rise_cnt < 18) begin
            sdin = 4'(slave_word >> (28 - 4 * (rise_cnt - 10)));
        end
    end

    // Drives one request on the CLK_DIV=2 instance and measures the response.
    // Cycle 1 is the cycle right after the acceptance edge.
    task automatic xfer(input logic wr, input logic rd, input logic [23:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        output int ack_cyc, output int ack_cnt,
                        output logic [7:0] snap, output logic busy_after);
        int cyc;
        ack_cyc    = -1;
        ack_cnt    = 0;
        snap       = '0;
        busy_after = 1'b1;
        cyc        = 0;
        @(posedge clk); #1;
        mon_n     = 0;
        reg_wr    = wr;
        reg_rd    = rd;
        reg_addr  = a;
        reg_be    = be;
        reg_wdata = wd;
        while (cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) snap = {ssn, sclk, sdout_oen, reg_busy, sdout};
            if (reg_ack) begin
                ack_cnt++;
                if (ack_cyc < 0) ack_cyc = cyc;
                reg_wr = 1'b0;
                reg_rd = 1'b0;
            end
            if (ack_cyc >= 0 && cyc == ack_cyc + 1) begin
                busy_after = reg_busy;
                break;
            end
        end
        reg_wr = 1'b0;
        reg_rd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ssn !== 1'b1)       begin errors++; $display("FAIL reset_ssn: got %b expected 1", ssn); end
        checks++; if (sclk !== 1'b0)      begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
        checks++; if (sdout !== 4'h0)     begin errors++; $display("FAIL reset_sdout: got %h expected 0", sdout); end
        checks++; if (sdout_oen !== 1'b1) begin errors++; $display("FAIL reset_oen: got %b expected 1", sdout_oen); end
        checks++; if (reg_ack !== 1'b0)   begin errors++; $display("FAIL reset_ack: got %b expected 0", reg_ack); end
        checks++; if (reg_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", reg_busy); end
        checks++; if (reg_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", reg_rdata); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_write();
        int ack_cyc, ack_cnt, bad;
        logic [7:0]  snap;
        logic        busy_after;
        logic [63:0] got;
        xfer(1'b1, 1'b0, 24'h00ABCD, 4'hF, 32'h12345678, ack_cyc, ack_cnt, snap, busy_after);
        got = '0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            got = {got[59:0], mon_nib[i]};
            if (mon_oen[i] !== 1'b0) bad++;
        end
        checks++; if (ack_cyc !== 70)   begin errors++; $display("FAIL write_ack_cycle: got %0d expected 70", ack_cyc); end
        checks++; if (ack_cnt !== 1)    begin errors++; $display("FAIL write_ack_width: got %0d expected 1", ack_cnt); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL write_busy_after: got %b expected 0", busy_after); end
        checks++; if (snap !== 8'h12)   begin errors++; $display("FAIL write_cs_setup: got %h expected 12", snap); end
        checks++; if (mon_n !== 16)     begin errors++; $display("FAIL write_sclk_count: got %0d expected 16", mon_n); end
        checks++; if (got !== 64'h2F00ABCD12345678) begin errors++; $display("FAIL write_nibbles: got %h expected 2f00abcd12345678", got); end
        checks++; if (bad !== 0)        begin errors++; $display("FAIL write_oen: got %0d bad samples expected 0", bad); end
    endtask

    task automatic test_read();
        int ack_cyc, ack_cnt, bad;
        logic [7:0]  snap;
        logic        busy_after;
        logic [31:0] got;
        xfer(1'b0, 1'b1, 24'h000010, 4'hF, 32'h0, ack_cyc, ack_cnt, snap, busy_after);
        got = '0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            got = {got[27:0], mon_nib[i]};
            if (mon_oen[i] !== 1'b0) bad++;
        end
        for (int i = 8; i < 18; i++) begin
            if (mon_oen[i] !== 1'b1 || mon_nib[i] !== 4'h0) bad++;
        end
        checks++; if (ack_cyc !== 78)   begin errors++; $display("FAIL read_ack_cycle: got %0d expected 78", ack_cyc); end
        checks++; if (ack_cnt !== 1)    begin errors++; $display("FAIL read_ack_width: got %0d expected 1", ack_cnt); end
        checks++; if (snap !== 8'h13)   begin errors++; $display("FAIL read_cs_setup: got %h expected 13", snap); end
        checks++; if (mon_n !== 18)     begin errors++; $display("FAIL read_sclk_count: got %0d expected 18", mon_n); end
        checks++; if (got !== 32'h3F000010) begin errors++; $display("FAIL read_cmd_addr: got %h expected 3f000010", got); end
        checks++; if (bad !== 0)        begin errors++; $display("FAIL read_turnaround_oen: got %0d bad samples expected 0", bad); end
        checks++; if (reg_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata: got %h expected deadbeef", reg_rdata); end
    endtask

    task automatic test_both();
        int ack_cyc, ack_cnt;
        logic [7:0]  snap;
        logic        busy_after;
        logic [63:0] got;
        xfer(1'b1, 1'b1, 24'h000040, 4'h3, 32'hA5A55A5A, ack_cyc, ack_cnt, snap, busy_after);
        got = '0;
        for (int i = 0; i < 16; i++) got = {got[59:0], mon_nib[i]};
        checks++; if (ack_cyc !== 70)   begin errors++; $display("FAIL both_ack_cycle: got %0d expected 70", ack_cyc); end
        checks++; if (mon_n !== 16)     begin errors++; $display("FAIL both_sclk_count: got %0d expected 16", mon_n); end
        checks++; if (got !== 64'h23000040A5A55A5A) begin errors++; $display("FAIL both_nibbles: got %h expected 23000040a5a55a5a", got); end
        checks++; if (reg_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL both_rdata_kept: got %h expected deadbeef", reg_rdata); end
    endtask

    task automatic test_reset_mid();
        int ack_cyc, ack_cnt, acks_seen;
        logic [7:0]  snap;
        logic        busy_after;
        logic [63:0] got;
        acks_seen = 0;
        @(posedge clk); #1;
        reg_wr = 1'b1; reg_addr = 24'h111111; reg_be = 4'hF; reg_wdata = 32'h22222222;
        // Cycle 20 falls inside the address phase.
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (reg_ack) acks_seen++;
        end
        rst = 1'b1;
        #1;
        checks++; if (ssn !== 1'b1)       begin errors++; $display("FAIL midrst_ssn: got %b expected 1", ssn); end
        checks++; if (sclk !== 1'b0)      begin errors++; $display("FAIL midrst_sclk: got %b expected 0", sclk); end
        checks++; if (sdout_oen !== 1'b1 || sdout !== 4'h0) begin errors++; $display("FAIL midrst_sdout: got oen=%b sdout=%h expected 1/0", sdout_oen, sdout); end
        checks++; if (reg_busy !== 1'b0)  begin errors++; $display("FAIL midrst_busy: got %b expected 0", reg_busy); end
        checks++; if (reg_rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h expected 0", reg_rdata); end
        reg_wr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (reg_ack) acks_seen++;
        end
        checks++; if (acks_seen !== 0) begin errors++; $display("FAIL midrst_no_ack: got %0d acks expected 0", acks_seen); end
        xfer(1'b1, 1'b0, 24'h123456, 4'h5, 32'hCAFEF00D, ack_cyc, ack_cnt, snap, busy_after);
        got = '0;
        for (int i = 0; i < 16; i++) got = {got[59:0], mon_nib[i]};
        checks++; if (ack_cyc !== 70) begin errors++; $display("FAIL midrst_after_ack: got %0d expected 70", ack_cyc); end
        checks++; if (got !== 64'h25123456CAFEF00D) begin errors++; $display("FAIL midrst_after_nibbles: got %h expected 25123456cafef00d", got); end
    endtask

    task automatic test_back_to_back();
        int cyc, nack, nrise, last_rise, rise_bad, hi_run, gap;
        int ack_cyc [2];
        logic sclk_prev, had_frame, ssn_prev, reraised;
        cyc = 0; nack = 0; nrise = 0; last_rise = -1; rise_bad = 0;
        hi_run = 0; gap = -1; sclk_prev = 1'b0; had_frame = 1'b0;
        ssn_prev = 1'b1; reraised = 1'b0;
        ack_cyc[0] = -1; ack_cyc[1] = -1;
        @(posedge clk); #1;
        wr1 = 1'b1; addr1 = 24'h000001; be1 = 4'hF; wdata1 = 32'h0F0F0F0F;
        while (nack < 2 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (ssn1) begin
                last_rise = -1;
                hi_run++;
            end else begin
                if (ssn_prev && had_frame && gap < 0) gap = hi_run;
                had_frame = 1'b1;
                hi_run = 0;
            end
            ssn_prev = ssn1;
            if (sclk1 && !sclk_prev) begin
                if (last_rise >= 0 && (cyc - last_rise) != 2) rise_bad++;
                last_rise = cyc;
                nrise++;
            end
            sclk_prev = sclk1;
            if (nack == 1 && !reraised) begin
                wr1 = 1'b1;
                reraised = 1'b1;
            end
            if (ack1) begin
                ack_cyc[nack] = cyc;
                nack++;
                wr1 = 1'b0;
            end
        end
        wr1 = 1'b0;
        checks++; if (nack !== 2)        begin errors++; $display("FAIL b2b_ack_count: got %0d expected 2", nack); end
        checks++; if (ack_cyc[0] !== 35) begin errors++; $display("FAIL b2b_first_ack: got %0d expected 35", ack_cyc[0]); end
        checks++; if ((ack_cyc[1] - ack_cyc[0]) !== 36) begin errors++; $display("FAIL b2b_ack_interval: got %0d expected 36", ack_cyc[1] - ack_cyc[0]); end
        checks++; if (gap < 2)           begin errors++; $display("FAIL b2b_ssn_gap: got %0d expected >=2", gap); end
        checks++; if (nrise !== 32)      begin errors++; $display("FAIL b2b_sclk_rises: got %0d expected 32", nrise); end
        checks++; if (rise_bad !== 0)    begin errors++; $display("FAIL b2b_sclk_period: got %0d bad periods expected 0", rise_bad); end
    endtask

    initial begin
        rst = 1'b1;
        reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_be = '0; reg_wdata = '0;
        sdin = 4'h0;
        wr1 = 1'b0; rd1 = 1'b0; addr1 = '0; be1 = '0; wdata1 = '0; sdin1 = 4'h0;
        test_reset();
        test_write();
        test_read();
        test_both();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/qspim_if.md
QSPIM_IF -- requirements
Module: qspim_if

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, sys_clk cycles per sclk half-period (legal range 1..255).
REQ-002 SHALL have parameter DUMMY_CYC, default 2, turnaround sclk cycles between address and read data (legal range 1..15).
REQ-003 SHALL have port sys_clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port reg_wr  input  1  write request, level, held until reg_ack.
REQ-006 SHALL have port reg_rd  input  1  read request, level, held until reg_ack.
REQ-007 SHALL have port reg_addr  input  24  transfer address.
REQ-008 SHALL have port reg_be  input  4  byte enables.
REQ-009 SHALL have port reg_wdata  input  32  write data.
REQ-010 SHALL have port reg_rdata  output  32  read data; valid from reg_ack until the next read's reg_ack.
REQ-011 SHALL have port reg_ack  output  1  one-cycle completion pulse.
REQ-012 SHALL have port reg_busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port sclk  output  1  SPI clock, mode 0 (idles low).
REQ-014 SHALL have port ssn  output  1  chip select, active-low.
REQ-015 SHALL have port sdout  output  4  quad data to slave.
REQ-016 SHALL have port sdout_oen  output  1  sdout output enable, active-low.
REQ-017 SHALL have port sdin  input  4  quad data from slave.

Function
REQ-018 SHALL implement states IDLE, CS_SETUP, CMD, ADDR, WDATA, DUMMY, RDATA, CS_HOLD, CS_IDLE.
REQ-019 SHALL accept a request in IDLE on a sys_clk edge where reg_wr or reg_rd is high; reg_wr wins if both high; addr/be/wdata captured at that edge.
REQ-020 SHALL ignore reg_wr/reg_rd outside IDLE; requester drops the request in the reg_ack cycle.
REQ-021 SHALL transfer every phase on all 4 lanes, most-significant nibble first.
REQ-022 SHALL send command byte {4'h2, be} for write, {4'h3, be} for read (2 sclk), then reg_addr[23:0] (6 sclk).
REQ-023 Write: WDATA sends reg_wdata[31:0] (8 sclk) with sdout_oen=0.
REQ-024 Read: DUMMY for DUMMY_CYC sclk with sdout_oen=1, then RDATA samples sdin on 8 sclk rising edges into a shift register.
REQ-025 SHALL change sdout only on sclk falling transitions (or at CS_SETUP entry); sdout=0 whenever sdout_oen=1.
REQ-026 sclk SHALL toggle every CLK_DIV sys_clk cycles during CMD/ADDR/WDATA/DUMMY/RDATA, starting low; each sclk cycle is 2*CLK_DIV sys_clk cycles; sclk low in all other states.
REQ-027 CS_SETUP: ssn=0, sclk=0, first nibble driven, for CLK_DIV cycles.
REQ-028 CS_HOLD: ssn=0, sclk=0, sdout_oen=1, for CLK_DIV cycles after last falling edge.
REQ-029 CS_IDLE: ssn=1 for CLK_DIV cycles; reg_ack high in its last cycle; reg_rdata updated in the same cycle for reads; next state IDLE.
REQ-030 Latency acceptance edge to reg_ack = (3 + 2*N)*CLK_DIV cycles, N = 16 (write) or 16+DUMMY_CYC (read); CLK_DIV=2: write 70, read 78 (DUMMY_CYC=2).
REQ-031 Back-to-back requests SHALL see ssn high for at least CLK_DIV+1 sys_clk cycles.
REQ-032 sdout_oen SHALL be 0 in CS_SETUP, CMD, ADDR, WDATA; 1 elsewhere.

Reset
REQ-033 On rst assertion, immediately: state IDLE, ssn=1, sclk=0, sdout=0, sdout_oen=1, reg_ack=0, reg_busy=0, reg_rdata=0, counters cleared.
REQ-034 Reset mid-transfer SHALL abort with no reg_ack; first request after deassertion starts a full new transfer.

Verification
REQ-035 Write addr=0x00ABCD be=0xF wdata=0x12345678, CLK_DIV=2 -> sdout nibbles 2,F,0,0,A,B,C,D,1,2,3,4,5,6,7,8 on rising sclk; reg_ack at cycle 70.
REQ-036 Read addr=0x000010 be=0xF, slave model drives 0xDEADBEEF after 2 dummy sclk -> reg_rdata=0xDEADBEEF, reg_ack at cycle 78, sdout_oen=1 from DUMMY.
REQ-037 reg_wr and reg_rd high together -> command nibble 2 sent, write transfer only.
REQ-038 rst pulsed during ADDR phase -> ssn=1, sclk=0 same cycle, no reg_ack; subsequent write completes normally.
REQ-039 Back-to-back writes with CLK_DIV=1 -> sclk period 2 cycles, ssn high >= 2 cycles between frames, both acked at 35-cycle intervals plus one IDLE cycle.
